// File: rtl/flappy_pkg.sv
// flappy_pkg: shared definitions for the game-side blocks.
//   - Pipe descriptor field layout: height, address and gap LSBs and widths.
//   - Game state enum used by pipe_scheduler.
//   - Park address for inactive pipes and the default display geometry.
package flappy_pkg;

    // Pipe descriptor layout: [9:0] height, [19:10] address, [27:20] gap, [31:28] zero
    localparam int HEIGHT_LSB = 0;
    localparam int HEIGHT_W   = 10;
    localparam int ADDR_LSB   = 10;
    localparam int ADDR_W     = 10;
    localparam int GAP_LSB    = 20;
    localparam int GAP_W      = 8;

    // Address given to an inactive pipe; lies beyond every visible column
    localparam int PARK_X     = 700;

    // Default display geometry
    localparam int H_DISPLAY  = 640;
    localparam int V_DISPLAY  = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } game_state_e;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
//   clk  in   system clock; steps on every rising edge
//   clrn in   asynchronous active-low reset; loads seed 16'hACE1
//   q    out  current register value; never zero
module lfsr16 (
    input  logic        clk,
    input  logic        clrn,
    output logic [15:0] q
);
    logic [15:0] q_q;
    logic        fb;

    assign fb = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) q_q <= 16'hACE1;
        else       q_q <= {q_q[14:0], fb};
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: owns the three pipe descriptors and the BCD score.
// On each frame_tick in RUN it scrolls, retires, scores and spawns pipes.
//   clk                    in   system clock
//   clrn                   in   asynchronous active-low reset
//   frame_tick             in   one-cycle pulse per video frame
//   start                  in   begin / restart a game (IDLE or DEAD)
//   fail                   in   collision; RUN -> DEAD
//   pipe_1/pipe_2/pipe_3   out  {4'h0, gap[7:0], address[9:0], height[9:0]}
//   score                  out  four BCD digits, [3:0] least significant
//   running                out  high while in RUN
//   pass                   out  one-cycle pulse when a pipe crosses the bird
module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter int SPEED   = 2,
    parameter int SPACING = 240,
    parameter int SPAWN_X = 640,
    parameter int PARK_X  = flappy_pkg::PARK_X,
    parameter int BIRD_X  = 40,
    parameter int H_MIN   = 40,
    parameter int GAP     = 120
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        fail,
    output logic [31:0] pipe_1,
    output logic [31:0] pipe_2,
    output logic [31:0] pipe_3,
    output logic [15:0] score,
    output logic        running,
    output logic        pass
);
    localparam int             NPIPE       = 3;
    localparam logic [9:0]     SPEED_A     = 10'(SPEED);
    localparam logic [9:0]     SPAWN_A     = 10'(SPAWN_X);
    localparam logic [9:0]     PARK_A      = 10'(PARK_X);
    localparam logic [9:0]     BIRD_A      = 10'(BIRD_X);
    localparam logic [9:0]     SPAWN_LIMIT = 10'(SPAWN_X - SPACING);
    localparam logic [7:0]     GAP_F       = 8'(GAP);

    game_state_e                state_q, state_d;
    logic [NPIPE-1:0][9:0]      addr_q, addr_d, mv_addr;
    logic [NPIPE-1:0][9:0]      height_q, height_d, mv_height;
    logic [NPIPE-1:0]           active_q, active_d, mv_active;
    logic [1:0]                 spawn_idx_q, spawn_idx_d;
    logic [1:0]                 last_idx_q, last_idx_d;
    logic [15:0]                score_q, score_d;
    logic                       pass_q, pass_d;
    logic                       running_q, running_d;

    logic                       crossed;
    logic [9:0]                 last_addr;
    logic                       spawn_free;
    logic                       spawn_go;
    logic [9:0]                 spawn_height;
    logic [15:0]                lfsr_q;
    logic                       lfsr_unused;
    logic [NPIPE-1:0][31:0]     desc;

    // BCD +1 with per-digit carry; holds at 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    lfsr16 u_lfsr (
        .clk  (clk),
        .clrn (clrn),
        .q    (lfsr_q)
    );

    // Only the low byte feeds the height
    assign lfsr_unused  = ^lfsr_q[15:8];
    assign spawn_height = 10'(H_MIN) + {2'b00, lfsr_q[7:0]};

    // Move / retire / score detection on pre-tick values, then the spawn
    // decision on the resulting post-move state.
    always_comb begin
        mv_addr    = addr_q;
        mv_height  = height_q;
        mv_active  = active_q;
        crossed    = 1'b0;
        last_addr  = PARK_A;
        spawn_free = 1'b0;
        for (int i = 0; i < NPIPE; i++) begin
            if (active_q[i]) begin
                if (addr_q[i] < SPEED_A) begin
                    mv_addr[i]   = PARK_A;
                    mv_height[i] = 10'd0;
                    mv_active[i] = 1'b0;
                end else begin
                    mv_addr[i] = addr_q[i] - SPEED_A;
                    if (addr_q[i] >= BIRD_A && mv_addr[i] < BIRD_A) crossed = 1'b1;
                end
            end
        end
        for (int i = 0; i < NPIPE; i++) begin
            if (last_idx_q == 2'(i))  last_addr  = mv_addr[i];
            if (spawn_idx_q == 2'(i)) spawn_free = !mv_active[i];
        end
        // A still-active target blocks the spawn and the index stays put
        spawn_go = ((mv_active == '0) || (last_addr <= SPAWN_LIMIT)) && spawn_free;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        height_d    = height_q;
        active_d    = active_q;
        spawn_idx_d = spawn_idx_q;
        last_idx_d  = last_idx_q;
        score_d     = score_q;
        pass_d      = 1'b0;
        case (state_q)
            IDLE, DEAD: begin
                if (start) begin
                    state_d     = RUN;
                    addr_d      = {NPIPE{PARK_A}};
                    height_d    = '0;
                    active_d    = '0;
                    score_d     = '0;
                    spawn_idx_d = 2'd0;
                    last_idx_d  = 2'd0;
                end
            end
            RUN: begin
                // fail has priority over a coincident tick: no motion
                if (fail) begin
                    state_d = DEAD;
                end else if (frame_tick) begin
                    addr_d   = mv_addr;
                    height_d = mv_height;
                    active_d = mv_active;
                    for (int i = 0; i < NPIPE; i++) begin
                        if (spawn_go && spawn_idx_q == 2'(i)) begin
                            addr_d[i]   = SPAWN_A;
                            height_d[i] = spawn_height;
                            active_d[i] = 1'b1;
                        end
                    end
                    if (spawn_go) begin
                        last_idx_d  = spawn_idx_q;
                        spawn_idx_d = (spawn_idx_q == 2'd2) ? 2'd0 : spawn_idx_q + 2'd1;
                    end
                    if (crossed) begin
                        score_d = bcd_inc(score_q);
                        pass_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            addr_q      <= {NPIPE{PARK_A}};
            height_q    <= '0;
            active_q    <= '0;
            spawn_idx_q <= 2'd0;
            last_idx_q  <= 2'd0;
            score_q     <= 16'h0000;
            pass_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            height_q    <= height_d;
            active_q    <= active_d;
            spawn_idx_q <= spawn_idx_d;
            last_idx_q  <= last_idx_d;
            score_q     <= score_d;
            pass_q      <= pass_d;
            running_q   <= running_d;
        end
    end

    for (genvar gi = 0; gi < NPIPE; gi++) begin : g_desc
        assign desc[gi] = {4'h0, GAP_F, addr_q[gi], height_q[gi]};
    end

    assign pipe_1  = desc[0];
    assign pipe_2  = desc[1];
    assign pipe_3  = desc[2];
    assign score   = score_q;
    assign running = running_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Scoreboard bench: instance A uses default parameters; instance B
// (SPEED=100, SPACING=100, BIRD_X=41) scores fast enough to reach BCD
// saturation and keeps all three pipes busy so spawns get skipped.
module tb_pipe_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn_a = 1'b0, start_a = 1'b0, fail_a = 1'b0, tick_a = 1'b0;
    logic        clrn_b = 1'b0, start_b = 1'b0, fail_b = 1'b0, tick_b = 1'b0;
    logic [31:0] p1_a, p2_a, p3_a, p1_b, p2_b, p3_b;
    logic [15:0] score_a, score_b;
    logic        running_a, running_b, pass_a, pass_b;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0]  rst_p = {4'h0, 8'd120, 10'd700, 10'd0};
    logic [113:0] qa[$];
    logic [113:0] qb[$];

    // Reference model state, index 0 = instance A, 1 = instance B
    int        m_addr[2][3];
    int        m_hgt[2][3];
    bit        m_act[2][3];
    int        m_sidx[2], m_last[2], m_score[2], m_st[2];
    bit        m_pass[2];
    bit [15:0] m_lfsr[2];

    pipe_scheduler u_dut_a (
        .clk(clk), .clrn(clrn_a), .frame_tick(tick_a), .start(start_a), .fail(fail_a),
        .pipe_1(p1_a), .pipe_2(p2_a), .pipe_3(p3_a),
        .score(score_a), .running(running_a), .pass(pass_a)
    );

    pipe_scheduler #(.SPEED(100), .SPACING(100), .BIRD_X(41)) u_dut_b (
        .clk(clk), .clrn(clrn_b), .frame_tick(tick_b), .start(start_b), .fail(fail_b),
        .pipe_1(p1_b), .pipe_2(p2_b), .pipe_3(p3_b),
        .score(score_b), .running(running_b), .pass(pass_b)
    );

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic model_step(input int u, input bit c, input bit s, input bit f, input bit t,
                              input int speed, input int spacing, input int bird);
        bit [15:0] l;
        bit        crossed;
        bit        any;
        int        k;
        l = m_lfsr[u];
        if (!c) begin
            for (int j = 0; j < 3; j++) begin
                m_addr[u][j] = 700; m_hgt[u][j] = 0; m_act[u][j] = 0;
            end
            m_sidx[u] = 0; m_last[u] = 0; m_score[u] = 0; m_st[u] = 0;
            m_pass[u] = 0; m_lfsr[u] = 16'hACE1;
        end else begin
            m_pass[u] = 0;
            crossed   = 0;
            if (m_st[u] != 1) begin
                if (s) begin
                    m_st[u] = 1;
                    for (int j = 0; j < 3; j++) begin
                        m_addr[u][j] = 700; m_hgt[u][j] = 0; m_act[u][j] = 0;
                    end
                    m_score[u] = 0; m_sidx[u] = 0; m_last[u] = 0;
                end
            end else if (f) begin
                m_st[u] = 2;
            end else if (t) begin
                for (int j = 0; j < 3; j++) begin
                    if (m_act[u][j]) begin
                        if (m_addr[u][j] < speed) begin
                            m_addr[u][j] = 700; m_hgt[u][j] = 0; m_act[u][j] = 0;
                        end else begin
                            if (m_addr[u][j] >= bird && m_addr[u][j] - speed < bird) crossed = 1;
                            m_addr[u][j] = m_addr[u][j] - speed;
                        end
                    end
                end
                any = m_act[u][0] | m_act[u][1] | m_act[u][2];
                if ((!any || m_addr[u][m_last[u]] <= 640 - spacing) && !m_act[u][m_sidx[u]]) begin
                    k = m_sidx[u];
                    m_addr[u][k] = 640;
                    m_hgt[u][k]  = 40 + int'(l[7:0]);
                    m_act[u][k]  = 1;
                    m_last[u]    = k;
                    m_sidx[u]    = (k + 1) % 3;
                end
                if (crossed) begin
                    m_pass[u] = 1;
                    if (m_score[u] < 9999) m_score[u]++;
                end
            end
            m_lfsr[u] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    function automatic logic [113:0] pack_exp(input int u);
        logic [31:0] p[3];
        logic [15:0] sc;
        int          s;
        for (int j = 0; j < 3; j++)
            p[j] = {4'h0, 8'd120, 10'(m_addr[u][j]), 10'(m_hgt[u][j])};
        s  = m_score[u];
        sc = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
        return {p[0], p[1], p[2], sc, (m_st[u] == 1), m_pass[u]};
    endfunction

    // Issue one clock of stimulus: expected responses go to the queues
    task automatic cyc();
        model_step(0, clrn_a, start_a, fail_a, tick_a, 2, 240, 40);
        qa.push_back(pack_exp(0));
        model_step(1, clrn_b, start_b, fail_b, tick_b, 100, 100, 41);
        qb.push_back(pack_exp(1));
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every registered output update against the queues
    initial begin
        logic [113:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("mon_a", {p1_a, p2_a, p3_a, score_a, running_a, pass_a}, e);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("mon_b", {p1_b, p2_b, p3_b, score_b, running_b, pass_b}, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen100;
        bit found;
        @(posedge clk);
        #2;
        repeat (2) cyc();
        check("rst_p1", p1_a, rst_p);
        check("rst_p2", p2_a, rst_p);
        check("rst_p3", p3_a, rst_p);
        check("rst_score_run_pass", {score_a, running_a, pass_a}, 18'd0);
        $display("reset: descriptors parked, score 0");

        // Spawn sequence; first height follows from the LFSR seed
        clrn_a = 1; clrn_b = 1; start_a = 1;
        cyc();
        start_a = 0; tick_a = 1;
        cyc();
        check("a_tick1_p1", p1_a, {4'h0, 8'd120, 10'd640, 10'd235});
        check("a_tick1_p2", p2_a, rst_p);
        $display("tick 1: pipe_1=%h", p1_a);
        repeat (120) cyc();
        check("a_t121_p1_addr", p1_a[19:10], 10'd400);
        check("a_t121_p2_addr", p2_a[19:10], 10'd640);
        $display("tick 121: pipe_1=%h pipe_2=%h", p1_a, p2_a);

        // Score at the 40 -> 38 crossing, then retire from address 0
        repeat (181) cyc();
        check("a_score1", score_a, 16'h0001);
        check("a_pass1", pass_a, 1'b1);
        check("a_cross_addr", p1_a[19:10], 10'd38);
        tick_a = 0;
        cyc();
        check("a_pass_drop", pass_a, 1'b0);
        tick_a = 1;
        repeat (19) cyc();
        check("a_addr0", p1_a[19:10], 10'd0);
        cyc();
        check("a_retire", p1_a, rst_p);
        $display("tick 322: score=%h pipe_1=%h", score_a, p1_a);

        // fail coincident with tick: frozen
        fail_a = 1;
        cyc();
        fail_a = 0;
        check("a_fail_run", running_a, 1'b0);
        check("a_fail_p2", p2_a[19:10], 10'd238);
        check("a_fail_p3", p3_a[19:10], 10'd478);
        repeat (5) cyc();
        check("a_dead_p3", p3_a[19:10], 10'd478);
        check("a_dead_score", score_a, 16'h0001);
        tick_a = 0; start_a = 1;
        cyc();
        start_a = 0;
        check("a_restart", {p1_a, p2_a, p3_a, score_a, running_a},
              {rst_p, rst_p, rst_p, 16'h0000, 1'b1});
        $display("restart: running=%0d score=%h", running_a, score_a);

        // Asynchronous reset mid-game
        tick_a = 1;
        repeat (10) cyc();
        clrn_a = 0;
        #1;
        check("a_async_p1", p1_a, rst_p);
        check("a_async_run", running_a, 1'b0);
        cyc();
        clrn_a = 1; start_a = 1; tick_a = 0;
        cyc();
        start_a = 0; tick_a = 1;
        cyc();
        check("a_reseed_p1", p1_a, {4'h0, 8'd120, 10'd640, 10'd235});
        tick_a = 0;
        $display("after clrn: pipe_1=%h", p1_a);

        // Instance B: spawn-skip and BCD saturation
        start_b = 1;
        cyc();
        start_b = 0; tick_b = 1;
        repeat (4) cyc();
        check("b_skip_addrs", {p1_b[19:10], p2_b[19:10], p3_b[19:10]},
              {10'd340, 10'd440, 10'd540});
        repeat (4) cyc();
        check("b_t8_addrs", {p1_b[19:10], p2_b[19:10]}, {10'd640, 10'd40});
        check("b_t8_score", score_b, 16'h0002);
        $display("B tick 8: pipe_1=%h score=%h", p1_b, score_b);
        seen100 = 0;
        for (int i = 0; i < 40000 && m_score[1] < 9999; i++) begin
            cyc();
            if (m_score[1] == 100 && !seen100) begin
                seen100 = 1;
                check("b_bcd_0100", score_b, 16'h0100);
                $display("B score reached %h", score_b);
            end
        end
        check("b_sat", score_b, 16'h9999);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (m_pass[1]) begin
                found = 1;
                check("b_sat_pass", pass_b, 1'b1);
                check("b_sat_hold", score_b, 16'h9999);
            end
        end
        if (!found) begin
            n_checks++;
            n_err++;
            $display("FAIL b_sat_wait: got no pass want pass within 20 ticks");
        end
        $display("B saturated: score=%h", score_b);
        tick_b = 0;
        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
